sram62256_ctrl: RTL and testbench

//  Bus-side controller for one external 62256 32Kx8 async SRAM. Accepts single-beat read/write

---
 rtl/sram62256_ctrl_pkg.sv | 31 +++
 rtl/sram62256_ctrl_timer.sv | 27 ++
 rtl/sram62256_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram62256_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram62256_ctrl_pkg.sv
// Shared types and constants for the 62256 SRAM controller.
package sram62256_ctrl_pkg;

    // Access sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WR_PULSE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    // Smallest legal value for any *_CYCLES parameter
    localparam int MIN_CYCLES = 1;

    // Largest of the four phase lengths
    function automatic int max_cycles(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Counter width wide enough to hold (max phase length - 1) without wrapping
    function automatic int cnt_width(input int max_cyc);
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/sram62256_ctrl_timer.sv
// Loadable down-counter that times each controller phase; done while the count is zero.
module sram62256_ctrl_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram62256_ctrl.sv
// Bus-side controller for one 62256 32Kx8 async SRAM: sequences nCS/nWE/nOE,
// address and data-bus enable for single-beat reads and writes.
module sram62256_ctrl
    import sram62256_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int WE_CYCLES    = 2,
    parameter int RD_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ncs,
    output logic              sram_nwe,
    output logic              sram_noe
);

    if (SETUP_CYCLES < MIN_CYCLES || WE_CYCLES < MIN_CYCLES ||
        RD_CYCLES < MIN_CYCLES || HOLD_CYCLES < MIN_CYCLES) begin : g_bad_cycles
        $error("sram62256_ctrl: every *_CYCLES parameter must be >= 1");
    end

    localparam int CNT_W = cnt_width(max_cycles(SETUP_CYCLES, WE_CYCLES, RD_CYCLES, HOLD_CYCLES));
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LD    = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    state_t            r_state;
    logic              r_we;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq_out;
    logic              r_dq_oe;
    logic              r_ncs;
    logic              r_nwe;
    logic              r_noe;

    logic              w_accept;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_value;
    logic              w_tmr_done;

    assign w_accept = req_valid && r_ready;

    // Reload the phase timer on every state entry with that phase's length minus one
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = r_we ? WE_LD : RD_LD;
                end
            end
            ST_WR_PULSE, ST_RD_WAIT: begin
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = HOLD_LD;
                end
            end
            default: ;
        endcase
    end

    sram62256_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    // Access sequencer with registered strobes, bus enable and handshake outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ncs       <= 1'b1;
            r_nwe       <= 1'b1;
            r_noe       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_dq_out <= req_wdata;
                        r_dq_oe  <= req_we;
                        r_ncs    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_done) begin
                        if (r_we) begin
                            r_nwe   <= 1'b0;
                            r_state <= ST_WR_PULSE;
                        end else begin
                            r_noe   <= 1'b0;
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_PULSE: begin
                    if (w_tmr_done) begin
                        r_ncs   <= 1'b1;
                        r_nwe   <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_tmr_done) begin
                        r_rdata <= sram_dq_in;
                        r_ncs   <= 1'b1;
                        r_noe   <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // dq_oe is still high here for writes, giving data hold past nWE rise
                    if (w_tmr_done) begin
                        r_dq_oe     <= 1'b0;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign sram_addr   = r_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ncs    = r_ncs;
    assign sram_nwe    = r_nwe;
    assign sram_noe    = r_noe;

endmodule

// File: tb/tb_sram62256_ctrl.sv
// Directed self-checking bench for sram62256_ctrl: default-timing instance plus a
// stretched-timing instance, each with a simple synchronous SRAM array behind it.
`timescale 1ns/1ps
module tb_sram62256_ctrl;

    localparam int T = 280;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;

    logic        d1_ready, d1_rsp, d1_oe, d1_ncs, d1_nwe, d1_noe;
    logic [7:0]  d1_rdata, d1_dqo, d1_dqi;
    logic [14:0] d1_addr;
    logic        d2_ready, d2_rsp, d2_oe, d2_ncs, d2_nwe, d2_noe;
    logic [7:0]  d2_rdata, d2_dqo, d2_dqi;
    logic [14:0] d2_addr;

    int checks = 0;
    int failures = 0;

    // sel=0 observes the default instance, sel=1 the stretched one
    logic        sel = 1'b0;
    logic        obs_ready, obs_rsp, obs_oe, obs_ncs, obs_nwe, obs_noe;
    logic [7:0]  obs_rdata, obs_dqo;
    logic [14:0] obs_addr;

    always #(T/2) clk = ~clk;

    sram62256_ctrl dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(d1_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d1_rsp), .rsp_rdata(d1_rdata), .sram_addr(d1_addr),
        .sram_dq_out(d1_dqo), .sram_dq_oe(d1_oe), .sram_dq_in(d1_dqi),
        .sram_ncs(d1_ncs), .sram_nwe(d1_nwe), .sram_noe(d1_noe)
    );

    sram62256_ctrl #(
        .SETUP_CYCLES(2), .WE_CYCLES(3), .RD_CYCLES(4), .HOLD_CYCLES(2)
    ) dut2 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(d2_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(d2_rsp), .rsp_rdata(d2_rdata), .sram_addr(d2_addr),
        .sram_dq_out(d2_dqo), .sram_dq_oe(d2_oe), .sram_dq_in(d2_dqi),
        .sram_ncs(d2_ncs), .sram_nwe(d2_nwe), .sram_noe(d2_noe)
    );

    // SRAM arrays: write while nCS/nWE low with the bus driven, read while nCS/nOE low
    logic [7:0] mem1 [0:32767];
    logic [7:0] mem2 [0:32767];
    always @(posedge clk) begin
        if (!d1_ncs && !d1_nwe && d1_oe) mem1[d1_addr] <= d1_dqo;
        if (!d2_ncs && !d2_nwe && d2_oe) mem2[d2_addr] <= d2_dqo;
    end
    assign d1_dqi = (!d1_ncs && !d1_noe) ? mem1[d1_addr] : 8'h00;
    assign d2_dqi = (!d2_ncs && !d2_noe) ? mem2[d2_addr] : 8'h00;

    assign obs_ready = sel ? d2_ready : d1_ready;
    assign obs_rsp   = sel ? d2_rsp   : d1_rsp;
    assign obs_oe    = sel ? d2_oe    : d1_oe;
    assign obs_ncs   = sel ? d2_ncs   : d1_ncs;
    assign obs_nwe   = sel ? d2_nwe   : d1_nwe;
    assign obs_noe   = sel ? d2_noe   : d1_noe;
    assign obs_rdata = sel ? d2_rdata : d1_rdata;
    assign obs_dqo   = sel ? d2_dqo   : d1_dqo;
    assign obs_addr  = sel ? d2_addr  : d1_addr;

    // Bus-safety invariants on both instances every cycle
    always @(negedge clk) begin
        if (nrst) begin
            checks++;
            if ((!d1_nwe && !d1_noe) || (d1_oe && !d1_noe) || ((!d1_nwe || !d1_noe) && d1_ncs) ||
                (!d2_nwe && !d2_noe) || (d2_oe && !d2_noe) || ((!d2_nwe || !d2_noe) && d2_ncs)) begin
                failures++;
                $display("FAIL invariant t=%0t d1 ncs,nwe,noe,oe=%b%b%b%b d2=%b%b%b%b required no strobe/bus conflict",
                         $time, d1_ncs, d1_nwe, d1_noe, d1_oe, d2_ncs, d2_nwe, d2_noe, d2_oe);
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #(T * 5000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access on the observed instance; called and returns at a negedge
    task automatic do_access(
        input  logic        we, input logic [14:0] a, input logic [7:0] d,
        input  logic        hold_valid, input logic nwe_next, input logic [14:0] na, input logic [7:0] nd,
        output int          lat, output int ncs_lo, output int nwe_lo, output int noe_lo,
        output int          oe_tail, output int wait_n,
        output logic        rsp_at_acc, output logic oe_at_acc,
        output logic [7:0]  rdata, output logic ok);
        logic seen_nwe;
        lat = 0; ncs_lo = 0; nwe_lo = 0; noe_lo = 0; oe_tail = 0; wait_n = 0;
        rdata = '0; ok = 1'b0; seen_nwe = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!obs_ready && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        rsp_at_acc = obs_rsp;
        oe_at_acc  = obs_oe;
        if (obs_ready) begin
            @(negedge clk);
            if (hold_valid) begin
                req_we = nwe_next; req_addr = na; req_wdata = nd;
            end else begin
                req_valid = 1'b0;
            end
            for (int n = 1; n <= 40; n++) begin
                if (!obs_ncs) ncs_lo++;
                if (!obs_nwe) begin
                    nwe_lo++;
                    seen_nwe = 1'b1;
                end else if (seen_nwe && obs_oe) begin
                    oe_tail++;
                end
                if (!obs_noe) noe_lo++;
                if (obs_rsp) begin
                    lat = n;
                    rdata = obs_rdata;
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
        end else begin
            req_valid = 1'b0;
        end
    endtask

    int          lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n;
    logic        rsp_acc, oe_acc, ok;
    logic [7:0]  rdata;

    task automatic test_reset();
        logic [38:0] got1, got2, want;
        nrst = 1'b1;
        #10;
        nrst = 1'b0;
        #1;
        want = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0, 8'h00, 8'h00, 1'b0};
        got1 = {d1_ready, d1_rsp, d1_ncs, d1_nwe, d1_noe, d1_oe, d1_addr, d1_dqo, d1_rdata, 1'b0};
        got2 = {d2_ready, d2_rsp, d2_ncs, d2_nwe, d2_noe, d2_oe, d2_addr, d2_dqo, d2_rdata, 1'b0};
        checks++;
        if (got1 !== want) begin
            failures++;
            $display("FAIL reset_state_default got=%h want=%h", got1, want);
        end
        checks++;
        if (got2 !== want) begin
            failures++;
            $display("FAIL reset_state_stretched got=%h want=%h", got2, want);
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        sel = 1'b0;
        do_access(1'b1, 15'h1234, 8'h42, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (!ok || lat != 5) begin
            failures++;
            $display("FAIL write_latency got=%0d (ok=%b) want=5", lat, ok);
        end
        checks++;
        if (ncs_lo != 3 || nwe_lo != 2 || noe_lo != 0) begin
            failures++;
            $display("FAIL write_strobes ncs/nwe/noe low got=%0d/%0d/%0d want=3/2/0", ncs_lo, nwe_lo, noe_lo);
        end
        checks++;
        if (oe_tail != 1) begin
            failures++;
            $display("FAIL write_data_hold dq_oe cycles after nwe rise got=%0d want=1", oe_tail);
        end
        @(negedge clk);
        checks++;
        if (obs_rsp !== 1'b0 || obs_oe !== 1'b0 || obs_addr !== 15'h1234 || obs_dqo !== 8'h42) begin
            failures++;
            $display("FAIL write_after rsp=%b oe=%b addr=%h dq=%h want rsp=0 oe=0 addr=1234 dq=42",
                     obs_rsp, obs_oe, obs_addr, obs_dqo);
        end
    endtask

    task automatic test_read();
        sel = 1'b0;
        do_access(1'b0, 15'h1234, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (oe_acc !== 1'b0) begin
            failures++;
            $display("FAIL read_bus_released dq_oe before ncs falls got=%b want=0", oe_acc);
        end
        checks++;
        if (!ok || lat != 5) begin
            failures++;
            $display("FAIL read_latency got=%0d (ok=%b) want=5", lat, ok);
        end
        checks++;
        if (ncs_lo != 3 || noe_lo != 2 || nwe_lo != 0) begin
            failures++;
            $display("FAIL read_strobes ncs/noe/nwe low got=%0d/%0d/%0d want=3/2/0", ncs_lo, noe_lo, nwe_lo);
        end
        checks++;
        if (rdata !== 8'h42) begin
            failures++;
            $display("FAIL read_data got=%h want=42", rdata);
        end
        @(negedge clk);
        checks++;
        if (obs_rsp !== 1'b0 || obs_rdata !== 8'h42) begin
            failures++;
            $display("FAIL read_held rsp=%b rdata=%h want rsp=0 rdata=42", obs_rsp, obs_rdata);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_access(1'b1, 15'h7FFF, 8'hA5, 1'b1, 1'b0, 15'h7FFF, 8'h00,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (!ok || lat != 5) begin
            failures++;
            $display("FAIL b2b_write_latency got=%0d (ok=%b) want=5", lat, ok);
        end
        do_access(1'b0, 15'h7FFF, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (wait_n != 0 || rsp_acc !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept wait=%0d rsp_at_accept=%b want wait=0 rsp=1", wait_n, rsp_acc);
        end
        checks++;
        if (!ok || lat != 5 || rdata !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_read lat=%0d data=%h want lat=5 data=a5", lat, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_idle();
        sel = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (d1_ready !== 1'b1 || d1_rsp !== 1'b0 || d1_ncs !== 1'b1 || d1_nwe !== 1'b1 ||
                d1_noe !== 1'b1 || d1_oe !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d ready,rsp,ncs,nwe,noe,oe=%b%b%b%b%b%b want 101110",
                         i, d1_ready, d1_rsp, d1_ncs, d1_nwe, d1_noe, d1_oe);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        int rsp_seen;
        sel = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0100; req_wdata = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (d1_nwe && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (d1_nwe !== 1'b0) begin
            failures++;
            $display("FAIL midreset_reach_wr nwe=%b want 0 within 10 cycles", d1_nwe);
        end
        #20;
        nrst = 1'b0;
        #1;
        checks++;
        if (d1_ncs !== 1'b1 || d1_nwe !== 1'b1 || d1_noe !== 1'b1 || d1_oe !== 1'b0 || d1_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release ncs,nwe,noe,oe,ready=%b%b%b%b%b want 11101",
                     d1_ncs, d1_nwe, d1_noe, d1_oe, d1_ready);
        end
        rsp_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (d1_rsp) rsp_seen++;
        end
        nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d1_rsp) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0) begin
            failures++;
            $display("FAIL midreset_no_rsp rsp pulses got=%0d want=0", rsp_seen);
        end
        do_access(1'b0, 15'h0100, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (!ok || lat != 5 || wait_n != 0) begin
            failures++;
            $display("FAIL midreset_recover lat=%0d wait=%0d ok=%b want lat=5 wait=0", lat, wait_n, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_params();
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        do_access(1'b1, 15'h0055, 8'h3C, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (!ok || lat != 8) begin
            failures++;
            $display("FAIL param_write_latency got=%0d (ok=%b) want=8", lat, ok);
        end
        checks++;
        if (ncs_lo != 5 || nwe_lo != 3 || oe_tail != 2) begin
            failures++;
            $display("FAIL param_write_widths ncs/nwe/oe_hold got=%0d/%0d/%0d want=5/3/2", ncs_lo, nwe_lo, oe_tail);
        end
        @(negedge clk);
        do_access(1'b0, 15'h0055, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0,
                  lat, ncs_lo, nwe_lo, noe_lo, oe_tail, wait_n, rsp_acc, oe_acc, rdata, ok);
        checks++;
        if (!ok || lat != 9) begin
            failures++;
            $display("FAIL param_read_latency got=%0d (ok=%b) want=9", lat, ok);
        end
        checks++;
        if (ncs_lo != 6 || noe_lo != 4 || rdata !== 8'h3C) begin
            failures++;
            $display("FAIL param_read ncs/noe got=%0d/%0d data=%h want=6/4 data=3c", ncs_lo, noe_lo, rdata);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_idle();
        test_reset_mid_write();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
